// File: rtl/mbtrain_sb_req_resp_seq.sv
// Purpose: initiator-side MBTRAIN sideband sequencer; START_REQ/START_RESP, counted LOCAL phase, END_REQ/END_RESP, repeated N_ITER times.
// Latency: all outputs registered; response-to-next-request turnaround through LOCAL is i_local_cycles+2 clocks.
// Backpressure: o_valid_tx is held until the sideband TX reports completion (busy negedge) while the RX side is not driving the mux.
//
// Ports:
//   clk, rst                    single clock, synchronous active-high reset
//   i_en                        substate enable; low returns to IDLE and clears everything
//   i_decoded_sideband_message  received message code, qualified by i_sideband_valid
//   i_busy_negedge_detected     sideband TX finished sending the current message
//   i_valid_rx                  receive side currently owns the sideband mux
//   i_local_cycles              extra LOCAL cycles per iteration, sampled on LOCAL entry
//   o_sideband_message          message code to transmit, qualified by o_valid_tx
//   o_test_ack                  all iterations completed
//   o_timeout_err               sticky response-timeout flag
//   o_iter_count                completed iterations
module mbtrain_sb_req_resp_seq #(
    parameter int                MSG_W          = 4,
    parameter logic [MSG_W-1:0]  START_REQ_MSG  = MSG_W'(1),
    parameter logic [MSG_W-1:0]  START_RESP_MSG = MSG_W'(2),
    parameter logic [MSG_W-1:0]  END_REQ_MSG    = MSG_W'(3),
    parameter logic [MSG_W-1:0]  END_RESP_MSG   = MSG_W'(4),
    parameter int                N_ITER         = 1,
    parameter int                ITER_W         = 4,
    parameter int                LOCAL_W        = 8,
    parameter int                TO_W           = 16,
    parameter int                TIMEOUT        = 1000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               i_en,
    input  logic [MSG_W-1:0]   i_decoded_sideband_message,
    input  logic               i_sideband_valid,
    input  logic               i_busy_negedge_detected,
    input  logic               i_valid_rx,
    input  logic [LOCAL_W-1:0] i_local_cycles,
    output logic [MSG_W-1:0]   o_sideband_message,
    output logic               o_valid_tx,
    output logic               o_test_ack,
    output logic               o_timeout_err,
    output logic [ITER_W-1:0]  o_iter_count
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_START_REQ = 3'd1,
        S_LOCAL     = 3'd2,
        S_END_REQ   = 3'd3,
        S_DONE      = 3'd4,
        S_ERROR     = 3'd5
    } state_e;

    // A TIMEOUT of 0 disables expiry; the counter then just wraps harmlessly.
    localparam bit                TO_EN     = (TIMEOUT != 0);
    localparam logic [TO_W-1:0]   TO_LAST   = TO_W'(TIMEOUT - 1);
    localparam logic [ITER_W-1:0] ITER_LAST = ITER_W'(N_ITER - 1);

    state_e             state_q, state_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic               vld_q, vld_d;
    logic               ack_q, ack_d;
    logic               err_q, err_d;
    logic [ITER_W-1:0]  iter_q, iter_d;
    logic [LOCAL_W-1:0] local_q, local_d;
    logic [TO_W-1:0]    to_q, to_d;

    logic start_resp_hit;
    logic end_resp_hit;
    logic to_expired;
    logic tx_done;

    always_comb begin
        start_resp_hit = i_sideband_valid && (i_decoded_sideband_message == START_RESP_MSG);
        end_resp_hit   = i_sideband_valid && (i_decoded_sideband_message == END_RESP_MSG);
        to_expired     = TO_EN && (to_q == TO_LAST);
        tx_done        = i_busy_negedge_detected && !i_valid_rx;
    end

    always_comb begin
        state_d = state_q;
        msg_d   = msg_q;
        vld_d   = vld_q;
        ack_d   = ack_q;
        err_d   = err_q;
        iter_d  = iter_q;
        local_d = local_q;
        to_d    = to_q;

        // Default handshake clear; any state that launches a request below
        // overrides it, so set wins over clear in the same cycle.
        if (tx_done) begin
            vld_d = 1'b0;
        end

        unique case (state_q)
            S_IDLE: begin
                // Only reachable with i_en=1; disable is handled in the flop block.
                state_d = S_START_REQ;
                msg_d   = START_REQ_MSG;
                vld_d   = 1'b1;
                to_d    = '0;
            end

            S_START_REQ: begin
                // The awaited response beats a simultaneous expiry.
                if (start_resp_hit) begin
                    state_d = S_LOCAL;
                    local_d = i_local_cycles;
                end else if (to_expired) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    msg_d   = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_LOCAL: begin
                if (local_q != '0) begin
                    local_d = local_q - LOCAL_W'(1);
                end else begin
                    state_d = S_END_REQ;
                    msg_d   = END_REQ_MSG;
                    vld_d   = 1'b1;
                    to_d    = '0;
                end
            end

            S_END_REQ: begin
                if (end_resp_hit) begin
                    iter_d = iter_q + ITER_W'(1);
                    if (iter_q == ITER_LAST) begin
                        state_d = S_DONE;
                        ack_d   = 1'b1;
                        msg_d   = '0;
                    end else begin
                        state_d = S_START_REQ;
                        msg_d   = START_REQ_MSG;
                        vld_d   = 1'b1;
                        to_d    = '0;
                    end
                end else if (to_expired) begin
                    state_d = S_ERROR;
                    err_d   = 1'b1;
                    vld_d   = 1'b0;
                    msg_d   = '0;
                end else begin
                    to_d = to_q + TO_W'(1);
                end
            end

            S_DONE, S_ERROR: begin
                // Terminal until i_en drops: everything, including the valid, frozen.
                vld_d = vld_q;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // rst and a low i_en both return to IDLE with everything cleared;
    // rst being listed first makes its priority explicit.
    always_ff @(posedge clk) begin
        if (rst || !i_en) begin
            state_q <= S_IDLE;
            msg_q   <= '0;
            vld_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            iter_q  <= '0;
            local_q <= '0;
            to_q    <= '0;
        end else begin
            state_q <= state_d;
            msg_q   <= msg_d;
            vld_q   <= vld_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            iter_q  <= iter_d;
            local_q <= local_d;
            to_q    <= to_d;
        end
    end

    assign o_sideband_message = msg_q;
    assign o_valid_tx         = vld_q;
    assign o_test_ack         = ack_q;
    assign o_timeout_err      = err_q;
    assign o_iter_count       = iter_q;

endmodule

// File: tb/tb_mbtrain_sb_req_resp_seq.sv
// Purpose: directed self-checking bench for mbtrain_sb_req_resp_seq.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: TX completion driven directly via busy-negedge / valid_rx inputs.
module tb_mbtrain_sb_req_resp_seq;

    logic       clk = 1'b0;
    logic       rst;
    logic       en;
    logic [3:0] sb_msg;
    logic       sb_vld;
    logic       busy_ne;
    logic       vld_rx;
    logic [7:0] local_cyc;

    logic [3:0] msg1, msg3;
    logic       vtx1, vtx3, ack1, ack3, err1, err3;
    logic [3:0] iter1, iter3;

    logic [10:0] obs1, obs3;
    logic [10:0] e;
    int checks = 0;
    int errors = 0;

    assign obs1 = {msg1, vtx1, ack1, err1, iter1};
    assign obs3 = {msg3, vtx3, ack3, err3, iter3};

    always #5 clk = ~clk;

    // Single-iteration instance.
    mbtrain_sb_req_resp_seq #(.N_ITER(1), .TIMEOUT(20)) u_dut1 (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (en),
        .i_decoded_sideband_message (sb_msg),
        .i_sideband_valid           (sb_vld),
        .i_busy_negedge_detected    (busy_ne),
        .i_valid_rx                 (vld_rx),
        .i_local_cycles             (local_cyc),
        .o_sideband_message         (msg1),
        .o_valid_tx                 (vtx1),
        .o_test_ack                 (ack1),
        .o_timeout_err              (err1),
        .o_iter_count               (iter1)
    );

    // Three-iteration instance sharing the same stimulus.
    mbtrain_sb_req_resp_seq #(.N_ITER(3), .TIMEOUT(20)) u_dut3 (
        .clk                        (clk),
        .rst                        (rst),
        .i_en                       (en),
        .i_decoded_sideband_message (sb_msg),
        .i_sideband_valid           (sb_vld),
        .i_busy_negedge_detected    (busy_ne),
        .i_valid_rx                 (vld_rx),
        .i_local_cycles             (local_cyc),
        .o_sideband_message         (msg3),
        .o_valid_tx                 (vtx3),
        .o_test_ack                 (ack3),
        .o_timeout_err              (err3),
        .o_iter_count               (iter3)
    );

    // Expected output vector: {msg, valid_tx, test_ack, timeout_err, iter_count}.
    function automatic logic [10:0] pack(input logic [3:0] m, input logic v, input logic a,
                                         input logic er, input logic [3:0] it);
        return {m, v, a, er, it};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [3:0] m);
        sb_msg = m;
        sb_vld = 1'b1;
        step(1);
        sb_vld = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1; en = 1'b0;
        step(2);
        checks++;
        if (obs1 !== 11'd0) begin errors++; $display("FAIL reset_dut1: got %h expected %h", obs1, 11'd0); end
        checks++;
        if (obs3 !== 11'd0) begin errors++; $display("FAIL reset_dut3: got %h expected %h", obs3, 11'd0); end
        rst = 1'b0;
        step(1);
        checks++;
        if (obs1 !== 11'd0) begin errors++; $display("FAIL idle_disabled: got %h expected %h", obs1, 11'd0); end
    endtask

    task automatic test_single_iter;
        local_cyc = 8'd0; en = 1'b1;
        step(1);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t1_start_req: got %h expected %h", obs1, e); end
        busy_ne = 1'b1; vld_rx = 1'b0;
        step(1);
        busy_ne = 1'b0;
        step(1);
        send(4'b0010);
        e = pack(4'b0001, 0, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t1_local: got %h expected %h", obs1, e); end
        step(1);
        e = pack(4'b0011, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t1_end_req: got %h expected %h", obs1, e); end
        busy_ne = 1'b1;
        step(1);
        busy_ne = 1'b0;
        step(1);
        send(4'b0100);
        e = pack(4'b0000, 0, 1, 0, 1);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t1_done: got %h expected %h", obs1, e); end
        sb_msg = 4'b0010; sb_vld = 1'b1;
        step(3);
        sb_vld = 1'b0;
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t1_done_held: got %h expected %h", obs1, e); end
        en = 1'b0;
        step(1);
        checks++;
        if (obs1 !== 11'd0) begin errors++; $display("FAIL t1_disable: got %h expected %h", obs1, 11'd0); end
    endtask

    task automatic test_multi_iter;
        local_cyc = 8'd5; en = 1'b1;
        step(1);
        for (int k = 0; k < 3; k++) begin
            e = pack(4'b0001, 1, 0, 0, 4'(k));
            checks++;
            if (obs3 !== e) begin errors++; $display("FAIL t2_start_req_%0d: got %h expected %h", k, obs3, e); end
            send(4'b0010);
            busy_ne = 1'b1; vld_rx = 1'b0;
            step(1);
            busy_ne = 1'b0;
            step(4);
            e = pack(4'b0001, 0, 0, 0, 4'(k));
            checks++;
            if (obs3 !== e) begin errors++; $display("FAIL t2_local_len_%0d: got %h expected %h", k, obs3, e); end
            step(1);
            e = pack(4'b0011, 1, 0, 0, 4'(k));
            checks++;
            if (obs3 !== e) begin errors++; $display("FAIL t2_end_req_%0d: got %h expected %h", k, obs3, e); end
            busy_ne = 1'b1;
            step(1);
            busy_ne = 1'b0;
            send(4'b0100);
            if (k < 2) e = pack(4'b0001, 1, 0, 0, 4'(k + 1));
            else       e = pack(4'b0000, 0, 1, 0, 4'd3);
            checks++;
            if (obs3 !== e) begin errors++; $display("FAIL t2_end_resp_%0d: got %h expected %h", k, obs3, e); end
        end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_timeout;
        en = 1'b1;
        step(1);
        // Unexpected END_RESP throughout: must not stop the timeout counting.
        sb_msg = 4'b0100; sb_vld = 1'b1;
        step(19);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t3_before_expiry: got %h expected %h", obs1, e); end
        step(1);
        e = pack(4'b0000, 0, 0, 1, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t3_error: got %h expected %h", obs1, e); end
        sb_msg = 4'b0010;
        step(3);
        sb_vld = 1'b0;
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t3_error_held: got %h expected %h", obs1, e); end
        en = 1'b0;
        step(1);
        checks++;
        if (obs1 !== 11'd0) begin errors++; $display("FAIL t3_clear: got %h expected %h", obs1, 11'd0); end
    endtask

    task automatic test_resp_at_expiry;
        local_cyc = 8'd3; en = 1'b1;
        step(20);
        send(4'b0010);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL resp_wins_expiry: got %h expected %h", obs1, e); end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_unexpected;
        local_cyc = 8'd0; en = 1'b1;
        step(1);
        send(4'b0100);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t4_ignore_0100: got %h expected %h", obs1, e); end
        send(4'b0011);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t4_ignore_0011: got %h expected %h", obs1, e); end
        send(4'b0010);
        step(1);
        e = pack(4'b0011, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t4_advance: got %h expected %h", obs1, e); end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_valid_handshake;
        local_cyc = 8'd0; en = 1'b1;
        step(1);
        busy_ne = 1'b1; vld_rx = 1'b1;
        step(1);
        checks++;
        if (vtx1 !== 1'b1) begin errors++; $display("FAIL t5_rx_blocks_clear: got %b expected 1", vtx1); end
        vld_rx = 1'b0;
        step(1);
        busy_ne = 1'b0;
        checks++;
        if (vtx1 !== 1'b0) begin errors++; $display("FAIL t5_clear: got %b expected 0", vtx1); end
        send(4'b0010);
        busy_ne = 1'b1;
        step(1);
        busy_ne = 1'b0;
        e = pack(4'b0011, 1, 0, 0, 0);
        checks++;
        if (obs1 !== e) begin errors++; $display("FAIL t5_set_beats_clear: got %h expected %h", obs1, e); end
        en = 1'b0;
        step(1);
    endtask

    task automatic test_disable_reset;
        local_cyc = 8'd5; en = 1'b1;
        step(1);
        send(4'b0010);
        step(2);
        en = 1'b0;
        step(1);
        checks++;
        if (obs3 !== 11'd0) begin errors++; $display("FAIL t6_en_drop: got %h expected %h", obs3, 11'd0); end
        en = 1'b1;
        step(1);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs3 !== e) begin errors++; $display("FAIL t6_restart: got %h expected %h", obs3, e); end
        send(4'b0010);
        step(6);
        send(4'b0100);
        e = pack(4'b0001, 1, 0, 0, 1);
        checks++;
        if (obs3 !== e) begin errors++; $display("FAIL t6_iter1: got %h expected %h", obs3, e); end
        send(4'b0010);
        step(6);
        e = pack(4'b0011, 1, 0, 0, 1);
        checks++;
        if (obs3 !== e) begin errors++; $display("FAIL t6_end_req: got %h expected %h", obs3, e); end
        rst = 1'b1;
        step(1);
        checks++;
        if (obs3 !== 11'd0) begin errors++; $display("FAIL t6_rst: got %h expected %h", obs3, 11'd0); end
        rst = 1'b0;
        step(1);
        e = pack(4'b0001, 1, 0, 0, 0);
        checks++;
        if (obs3 !== e) begin errors++; $display("FAIL t6_after_rst: got %h expected %h", obs3, e); end
        en = 1'b0;
        step(1);
    endtask

    initial begin
        rst = 1'b1; en = 1'b0; sb_msg = 4'd0; sb_vld = 1'b0;
        busy_ne = 1'b0; vld_rx = 1'b0; local_cyc = 8'd0;
        test_reset();
        test_single_iter();
        test_multi_iter();
        test_timeout();
        test_resp_at_expiry();
        test_unexpected();
        test_valid_handshake();
        test_disable_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d errors=%0d", checks, errors);
        $fatal(1);
    end

endmodule
